display_scan_scheduler: RTL and testbench

DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

---
 rtl/display_scan_scheduler.sv | 146 ++++++++++++++
 tb/tb_display_scan_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// Two-digit multiplexed display scanner with double-buffered digit pair.
// Ports: clk, reset (async, high), load_valid/ready, load_left/right [3:0],
//   blank, digit [3:0], select [1:0] (10 left, 01 right), frame_done.
// Option: define DEADTIME_EN to insert GAP_CYCLES of blanking between
//   digits; otherwise only the post-reset GAP_LR cycle remains.
module display_scan_scheduler #(
  parameter int unsigned DWELL_CYCLES = 24000,
  parameter int unsigned GAP_CYCLES   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [3:0] load_left,
  input  logic [3:0] load_right,
  output logic       load_ready,
  input  logic       blank,
  output logic [3:0] digit,
  output logic [1:0] select,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    SHOW_R,
    GAP_RL,
    SHOW_L,
    GAP_LR
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
`ifdef DEADTIME_EN
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
`else
  // gaps collapse; the reset GAP_LR holds for a single cycle
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - GAP_CYCLES);
`endif

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [3:0]  disp_l;
  logic [3:0]  disp_r;
  logic [3:0]  pend_l;
  logic [3:0]  pend_r;
  logic [3:0]  disp_l_n;
  logic [3:0]  disp_r_n;
  logic        boundary;
  logic        take;
  logic        accept;
  logic [1:0]  sel_n;
  logic [3:0]  dig_n;

  always_comb begin
    state_n = state;
    unique case (state)
      SHOW_R: begin
        if (cnt == DWELL_LAST) begin
`ifdef DEADTIME_EN
          state_n = GAP_RL;
`else
          state_n = SHOW_L;
`endif
        end
      end
      GAP_RL: begin
        if (cnt == GAP_LAST)
          state_n = SHOW_L;
      end
      SHOW_L: begin
        if (cnt == DWELL_LAST) begin
`ifdef DEADTIME_EN
          state_n = GAP_LR;
`else
          state_n = SHOW_R;
`endif
        end
      end
      GAP_LR: begin
        if (cnt == GAP_LAST)
          state_n = SHOW_R;
      end
      default: state_n = GAP_LR;
    endcase
  end

  // Frame boundary: the edge entering SHOW_R. A full pending
  // register (load_ready low) is swapped onto the display there.
  assign boundary = (state_n == SHOW_R) && (state != SHOW_R);
  assign take     = boundary && !load_ready;
  assign accept   = load_valid && load_ready;
  assign disp_l_n = take ? pend_l : disp_l;
  assign disp_r_n = take ? pend_r : disp_r;

  always_comb begin
    sel_n = 2'b00;
    dig_n = 4'h0;
    unique case (1'b1)
      (state_n == SHOW_R): begin
        sel_n = 2'b01;
        dig_n = disp_r_n;
      end
      (state_n == SHOW_L): begin
        sel_n = 2'b10;
        dig_n = disp_l_n;
      end
      default: begin
        sel_n = 2'b00;
        dig_n = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GAP_LR;
      cnt        <= 16'd0;
      select     <= 2'b00;
      digit      <= 4'h0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
      disp_l     <= 4'h0;
      disp_r     <= 4'h0;
      pend_l     <= 4'h0;
      pend_r     <= 4'h0;
    end else begin
      state      <= state_n;
      cnt        <= (state_n != state) ? 16'd0 : cnt + 16'd1;
      frame_done <= take;
      disp_l     <= disp_l_n;
      disp_r     <= disp_r_n;
      // accept and take are exclusive: one needs ready high,
      // the other needs it low
      if (accept) begin
        pend_l     <= load_left;
        pend_r     <= load_right;
        load_ready <= 1'b0;
      end else if (take) begin
        load_ready <= 1'b1;
      end
      // blank is sampled like every other input: it darkens the
      // select lines from the next edge, the scan keeps running
      select <= blank ? 2'b00 : sel_n;
      digit  <= dig_n;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler (DWELL=4, GAP=2).
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_display_scan_scheduler;

  localparam int D = 4;
`ifdef DEADTIME_EN
  localparam int G  = 2;
  localparam int IG = 2;
`else
  localparam int G  = 0;
  localparam int IG = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] load_left = 4'h0;
  logic [3:0] load_right = 4'h0;
  logic       blank = 1'b0;
  logic       load_ready;
  logic [3:0] digit;
  logic [1:0] select;
  logic       frame_done;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] dig;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   ncyc = 0;
  int   blank_plan = 0;
  logic prev_blank = 1'b0;

  always #5 clk = ~clk;

  display_scan_scheduler #(
    .DWELL_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_left(load_left),
    .load_right(load_right),
    .load_ready(load_ready),
    .blank(blank),
    .digit(digit),
    .select(select),
    .frame_done(frame_done)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      ncyc++;
      tests++;
      if (select !== m_e.sel) begin
        fails++;
        $display("FAIL select cyc=%0d got=%b exp=%b", ncyc, select, m_e.sel);
      end
      tests++;
      if (digit !== m_e.dig) begin
        fails++;
        $display("FAIL digit cyc=%0d got=%h exp=%h", ncyc, digit, m_e.dig);
      end
      tests++;
      if (frame_done !== m_e.fd) begin
        fails++;
        $display("FAIL frame_done cyc=%0d got=%b exp=%b",
                 ncyc, frame_done, m_e.fd);
      end
      tests++;
      if (load_ready !== m_e.rdy) begin
        fails++;
        $display("FAIL load_ready cyc=%0d got=%b exp=%b",
                 ncyc, load_ready, m_e.rdy);
      end
    end
  end

  // One cycle: queue what the outputs must show now, drive blank,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic [1:0] s, input logic [3:0] d,
                     input logic fd, input logic rdy);
    exp_t e;
    e.sel = prev_blank ? 2'b00 : s;
    e.dig = d;
    e.fd  = fd;
    e.rdy = rdy;
    blank = (blank_plan > 0);
    if (blank_plan > 0)
      blank_plan--;
    prev_blank = blank;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [1:0] s, input logic [3:0] d,
                      input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      cyc(s, d, 1'b0, rdy);
  endtask

  task automatic gap(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      cyc(2'b00, 4'h0, 1'b0, rdy);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset held: dark, ready
    cyc(2'b00, 4'h0, 1'b0, 1'b1);
    cyc(2'b00, 4'h0, 1'b0, 1'b1);
    reset = 1'b0;
    // idle scan from GAP_LR, zeros shown
    gap(IG, 1'b1);
    repeat (2) begin
      show(2'b01, 4'h0, D, 1'b1);
      gap(G, 1'b1);
      show(2'b10, 4'h0, D, 1'b1);
      gap(G, 1'b1);
    end
    // frame 3: load A/3 mid SHOW_L, then hold 5/6 while full
    show(2'b01, 4'h0, D, 1'b1);
    gap(G, 1'b1);
    show(2'b10, 4'h0, 2, 1'b1);
    load_valid = 1'b1;
    load_left  = 4'hA;
    load_right = 4'h3;
    cyc(2'b10, 4'h0, 1'b0, 1'b1);
    load_left  = 4'h5;
    load_right = 4'h6;
    cyc(2'b10, 4'h0, 1'b0, 1'b0);
    gap(G, 1'b0);
    // frame 4: A/3 applied, 5/6 accepted on this cycle's edge
    cyc(2'b01, 4'h3, 1'b1, 1'b1);
    load_valid = 1'b0;
    load_left  = 4'h0;
    load_right = 4'h0;
    show(2'b01, 4'h3, D - 1, 1'b0);
    gap(G, 1'b0);
    show(2'b10, 4'hA, D, 1'b0);
    gap(G, 1'b0);
    // frame 5: 5/6 applied; blank for 10 cycles from R2
    cyc(2'b01, 4'h6, 1'b1, 1'b1);
    blank_plan = 10;
    cyc(2'b01, 4'h6, 1'b0, 1'b1);
    show(2'b01, 4'h6, D - 2, 1'b1);
    gap(G, 1'b1);
    show(2'b10, 4'h5, D, 1'b1);
    gap(G, 1'b1);
    // frame 6: load F/1, then reset mid SHOW_R
    load_valid = 1'b1;
    load_left  = 4'hF;
    load_right = 4'h1;
    cyc(2'b01, 4'h6, 1'b0, 1'b1);
    load_valid = 1'b0;
    cyc(2'b01, 4'h6, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(2'b00, 4'h0, 1'b0, 1'b1);
    cyc(2'b00, 4'h0, 1'b0, 1'b1);
    reset = 1'b0;
    // F/1 was discarded: zeros, no frame_done
    gap(IG, 1'b1);
    show(2'b01, 4'h0, D, 1'b1);
    gap(G, 1'b1);
    show(2'b10, 4'h0, D, 1'b1);
    gap(G, 1'b1);
    cyc(2'b01, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
